// File: rtl/serpent_round_engine.sv
// -----------------------------------------------------------------------------
// serpent_round_engine
// Iterative Serpent-128 encryption datapath: 32 rounds, one per clock, on a
// block that has already been through the initial permutation. The result is
// left in the same (pre-final-permutation) bit order.
//
// Ports
//   i_clk      : clock, all state changes on the rising edge
//   i_rst_n    : synchronous active-low reset
//   i_start    : start request, only honoured while o_ready is high
//   i_data     : post-IP plaintext, captured when i_start is accepted
//   o_ready    : high while idle
//   o_key_idx  : registered subkey RAM address (0..32)
//   i_subkey   : subkey RAM data, one-cycle latency behind o_key_idx
//   o_data     : pre-FP ciphertext, held until the next result
//   o_valid    : one-cycle pulse marking a new o_data
// -----------------------------------------------------------------------------
module serpent_round_engine (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [127:0] i_data,
  output logic         o_ready,
  output logic [5:0]   o_key_idx,
  input  logic [127:0] i_subkey,
  output logic [127:0] o_data,
  output logic         o_valid
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_FINAL = 2'd3;

  // Serpent S-box lookup. Each table packs entry i into bits [4i+3:4i].
  function automatic logic [3:0] sbox_nib(input logic [2:0] box, input logic [3:0] nib);
    logic [63:0] tbl;
    case (box)
      3'd0:    tbl = 64'hC90724DEB56A1F83;
      3'd1:    tbl = 64'h43D68EB1A50972CF;
      3'd2:    tbl = 64'h25B04E1DFAC39768;
      3'd3:    tbl = 64'hE57A421D369C8BF0;
      3'd4:    tbl = 64'hD7E9A4526B0C38F1;
      3'd5:    tbl = 64'h176D8E30C9A4B25F;
      3'd6:    tbl = 64'h0A3DF19EB6485C27;
      3'd7:    tbl = 64'h6539AC47B28E0FD1;
      default: tbl = 64'h6539AC47B28E0FD1;
    endcase
    return tbl[{nib, 2'b00} +: 4];
  endfunction

  // Same S-box applied to all 32 nibbles of the state.
  function automatic logic [127:0] sbox_layer(input logic [2:0] box, input logic [127:0] v);
    logic [127:0] res;
    res = 128'd0;
    for (int k = 0; k < 32; k++) begin
      res[4*k +: 4] = sbox_nib(box, v[4*k +: 4]);
    end
    return res;
  endfunction

  // Linear transform. Word j gathers bit j of every nibble, so the
  // word-oriented LT operates directly on the nibble-ordered state.
  function automatic logic [127:0] lin_xform(input logic [127:0] v);
    logic [31:0]  x0, x1, x2, x3;
    logic [127:0] res;
    for (int k = 0; k < 32; k++) begin
      x0[k] = v[4*k];
      x1[k] = v[4*k+1];
      x2[k] = v[4*k+2];
      x3[k] = v[4*k+3];
    end
    x0 = {x0[18:0], x0[31:19]};
    x2 = {x2[28:0], x2[31:29]};
    x1 = x1 ^ x0 ^ x2;
    x3 = x3 ^ x2 ^ {x0[28:0], 3'b000};
    x1 = {x1[30:0], x1[31]};
    x3 = {x3[24:0], x3[31:25]};
    x0 = x0 ^ x1 ^ x3;
    x2 = x2 ^ x3 ^ {x1[24:0], 7'b0000000};
    x0 = {x0[26:0], x0[31:27]};
    x2 = {x2[9:0], x2[31:10]};
    res = 128'd0;
    for (int k = 0; k < 32; k++) begin
      res[4*k]   = x0[k];
      res[4*k+1] = x1[k];
      res[4*k+2] = x2[k];
      res[4*k+3] = x3[k];
    end
    return res;
  endfunction

  logic [1:0]   state_q, state_d;
  logic [127:0] s_q, s_d;
  logic [4:0]   r_q, r_d;
  logic [5:0]   key_idx_q, key_idx_d;
  logic [127:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         ready_q, ready_d;

  logic [127:0] sbox_out_s;
  logic [127:0] round_out_s;

  // Round datapath: subkey mix, S-box (index r mod 8), then LT except on round 31.
  always_comb begin
    sbox_out_s = sbox_layer(r_q[2:0], s_q ^ i_subkey);
    if (r_q == 5'd31) begin
      round_out_s = sbox_out_s;
    end else begin
      round_out_s = lin_xform(sbox_out_s);
    end
  end

  // Control FSM and next-state values for all registers.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    r_d       = r_q;
    key_idx_d = key_idx_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ready_d   = ready_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          s_d       = i_data;
          key_idx_d = 6'd0;
          ready_d   = 1'b0;
          state_d   = ST_PRIME;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRIME: begin
        // K0 is on i_subkey next cycle; request K1 now to keep the pipe full.
        key_idx_d = 6'd1;
        r_d       = 5'd0;
        state_d   = ST_ROUND;
      end
      ST_ROUND: begin
        s_d = round_out_s;
        r_d = r_q + 5'd1;
        // Address runs two ahead of the round and stops at K32.
        if (r_q >= 5'd30) begin
          key_idx_d = 6'd32;
        end else begin
          key_idx_d = {1'b0, r_q} + 6'd2;
        end
        if (r_q == 5'd31) begin
          state_d = ST_FINAL;
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_FINAL: begin
        data_d    = s_q ^ i_subkey;
        valid_d   = 1'b1;
        key_idx_d = 6'd0;
        ready_d   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        key_idx_d = 6'd0;
        ready_d   = 1'b1;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      s_q       <= 128'd0;
      r_q       <= 5'd0;
      key_idx_q <= 6'd0;
      data_q    <= 128'd0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      r_q       <= r_d;
      key_idx_q <= key_idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_key_idx = key_idx_q;
  assign o_data    = data_q;
  assign o_valid   = valid_q;

endmodule

// File: tb/tb_serpent_round_engine.sv
// -----------------------------------------------------------------------------
// tb_serpent_round_engine
// Self-checking bench. The reference model is a bitsliced Serpent-128
// (word-oriented, un-permuted data, full key schedule); the bench applies IP
// to plaintext and subkeys going into the engine and FP to its result.
// -----------------------------------------------------------------------------
module tb_serpent_round_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] data_in;
  logic         ready;
  logic [5:0]   key_idx;
  logic [127:0] subkey;
  logic [127:0] data_out;
  logic         valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] mk  [0:32];   // subkeys, bitsliced word form
  logic [127:0] ram [0:32];   // subkeys as seen by the engine (IP applied)

  localparam int SB [8][16] = '{
    '{ 3,  8, 15,  1, 10,  6,  5, 11, 14, 13,  4,  2,  7,  0,  9, 12},
    '{15, 12,  2,  7,  9,  0,  5, 10,  1, 11, 14,  8,  6, 13,  3,  4},
    '{ 8,  6,  7,  9,  3, 12, 10, 15, 13,  1, 14,  4,  0, 11,  5,  2},
    '{ 0, 15, 11,  8, 12,  9,  6,  3, 13,  1,  2,  4, 10,  7,  5, 14},
    '{ 1, 15,  8,  3, 12,  0, 11,  6,  2,  5,  4, 10,  9, 14,  7, 13},
    '{15,  5,  2, 11,  4, 10,  9, 12,  0,  3, 14,  8, 13,  6,  7,  1},
    '{ 7,  2, 12,  5,  8,  4,  6, 11, 14,  9,  1, 15, 13,  3, 10,  0},
    '{ 1, 13, 15,  0, 14,  8,  2, 11,  7,  4, 12, 10,  9,  3,  5,  6}
  };

  serpent_round_engine dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_data    (data_in),
    .o_ready   (ready),
    .o_key_idx (key_idx),
    .i_subkey  (subkey),
    .o_data    (data_out),
    .o_valid   (valid)
  );

  always #5 clk = ~clk;

  // Synchronous key RAM, one-cycle read latency.
  always @(posedge clk) subkey <= ram[key_idx];

  // ---------------- reference model ----------------
  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Column-wise S-box across the four words (word 0 supplies the LSB).
  function automatic logic [127:0] col_sbox(input int box, input logic [127:0] w);
    logic [127:0] o;
    logic [3:0]   y;
    int           v;
    o = '0;
    for (int k = 0; k < 32; k++) begin
      v = int'(w[k]) + 2 * int'(w[32+k]) + 4 * int'(w[64+k]) + 8 * int'(w[96+k]);
      y = 4'(SB[box][v]);
      o[k] = y[0]; o[32+k] = y[1]; o[64+k] = y[2]; o[96+k] = y[3];
    end
    return o;
  endfunction

  function automatic logic [127:0] lt_words(input logic [127:0] w);
    logic [31:0] x0, x1, x2, x3;
    x0 = w[31:0]; x1 = w[63:32]; x2 = w[95:64]; x3 = w[127:96];
    x0 = rol(x0, 13); x2 = rol(x2, 3);
    x1 = x1 ^ x0 ^ x2; x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = rol(x1, 1); x3 = rol(x3, 7);
    x0 = x0 ^ x1 ^ x3; x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = rol(x0, 5); x2 = rol(x2, 22);
    return {x3, x2, x1, x0};
  endfunction

  function automatic logic [127:0] ip(input logic [127:0] w);
    logic [127:0] s;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 32; k++) s[4*k+j] = w[32*j+k];
    return s;
  endfunction

  function automatic logic [127:0] fp(input logic [127:0] s);
    logic [127:0] w;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 32; k++) w[32*j+k] = s[4*k+j];
    return w;
  endfunction

  task automatic make_subkeys(input logic [127:0] key);
    logic [31:0] w [0:139];
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    w[4] = 32'h1; w[5] = 32'h0; w[6] = 32'h0; w[7] = 32'h0;
    for (int i = 0; i < 132; i++)
      w[i+8] = rol(w[i] ^ w[i+3] ^ w[i+5] ^ w[i+7] ^ 32'h9e3779b9 ^ 32'(i), 11);
    for (int n = 0; n < 33; n++) begin
      mk[n]  = col_sbox((35 - n) % 8, {w[8+4*n+3], w[8+4*n+2], w[8+4*n+1], w[8+4*n]});
      ram[n] = ip(mk[n]);
    end
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] w;
    w = pt;
    for (int r = 0; r < 32; r++) begin
      w = col_sbox(r % 8, w ^ mk[r]);
      if (r < 31) w = lt_words(w);
    end
    return w ^ mk[32];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a start on the next edge (T); returns in cycle T+1.
  task automatic start_op(input logic [127:0] pt);
    start   = 1'b1;
    data_in = ip(pt);
    step();
    start   = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; data_in = rnd128();
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (ready !== 1'b1 || valid !== 1'b0 || data_out !== 128'd0 || key_idx !== 6'd0) begin
        n_fail++;
        $display("FAIL reset_state: ready=%b valid=%b key_idx=%0d data=%h, required 1 0 0 0",
                 ready, valid, key_idx, data_out);
      end
    end
    rst_n = 1'b1; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (ready !== 1'b1 || valid !== 1'b0 || key_idx !== 6'd0) begin
        n_fail++;
        $display("FAIL reset_no_start: ready=%b valid=%b key_idx=%0d, required 1 0 0",
                 ready, valid, key_idx);
      end
    end
  endtask

  task automatic test_known_answer();
    logic [127:0] exp;
    make_subkeys(128'd0);
    exp = encrypt(128'd0);
    start_op(128'd0);
    for (int n = 1; n <= 36; n++) begin
      n_checks++;
      if (valid !== (n == 35)) begin
        n_fail++;
        $display("FAIL kat_valid_timing: cycle T+%0d valid=%b required %b", n, valid, (n == 35));
      end
      if (n == 35) begin
        n_checks++;
        if (fp(data_out) !== exp) begin
          n_fail++;
          $display("FAIL kat_result: got %h required %h", fp(data_out), exp);
        end
      end
      step();
    end
  endtask

  task automatic test_key_addressing();
    logic [5:0] exp_idx;
    make_subkeys(rnd128());
    start_op(rnd128());
    for (int n = 1; n <= 35; n++) begin
      if (n == 35) exp_idx = 6'd0;
      else if (n - 1 > 32) exp_idx = 6'd32;
      else exp_idx = 6'(n - 1);
      n_checks++;
      if (key_idx !== exp_idx || ready !== (n == 35)) begin
        n_fail++;
        $display("FAIL key_addressing: cycle T+%0d key_idx=%0d ready=%b required %0d %b",
                 n, key_idx, ready, exp_idx, (n == 35));
      end
      step();
    end
  endtask

  task automatic test_busy_start();
    logic [127:0] a, b, exp_a;
    make_subkeys(rnd128());
    a = rnd128(); b = rnd128(); exp_a = encrypt(a);
    start_op(a);
    for (int n = 1; n <= 75; n++) begin
      n_checks++;
      if (valid !== (n == 35)) begin
        n_fail++;
        $display("FAIL busy_valid: cycle T+%0d valid=%b required %b", n, valid, (n == 35));
      end
      if (n >= 35) begin
        n_checks++;
        if (fp(data_out) !== exp_a) begin
          n_fail++;
          $display("FAIL busy_result: cycle T+%0d got %h required %h", n, fp(data_out), exp_a);
        end
      end
      if (n == 5) begin
        start = 1'b1; data_in = ip(b);
      end else begin
        start = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, b, exp_a, exp_b;
    make_subkeys(rnd128());
    a = rnd128(); b = rnd128();
    exp_a = encrypt(a); exp_b = encrypt(b);
    start_op(a);
    for (int n = 1; n <= 71; n++) begin
      n_checks++;
      if (valid !== (n == 35 || n == 70)) begin
        n_fail++;
        $display("FAIL b2b_valid: cycle T+%0d valid=%b required %b", n, valid, (n == 35 || n == 70));
      end
      if (n >= 35 && n <= 69) begin
        n_checks++;
        if (fp(data_out) !== exp_a) begin
          n_fail++;
          $display("FAIL b2b_first_hold: cycle T+%0d got %h required %h", n, fp(data_out), exp_a);
        end
      end
      if (n == 35) begin
        n_checks++;
        if (ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready: ready=%b required 1", ready);
        end
        start = 1'b1; data_in = ip(b);
      end else begin
        start = 1'b0;
      end
      if (n == 70) begin
        n_checks++;
        if (fp(data_out) !== exp_b) begin
          n_fail++;
          $display("FAIL b2b_second_result: got %h required %h", fp(data_out), exp_b);
        end
      end
      step();
    end
  endtask

  task automatic test_mid_reset();
    logic [127:0] c, exp_c;
    make_subkeys(rnd128());
    start_op(rnd128());
    for (int n = 1; n < 20; n++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if (ready !== 1'b1 || valid !== 1'b0 || data_out !== 128'd0 || key_idx !== 6'd0) begin
      n_fail++;
      $display("FAIL mid_reset_state: ready=%b valid=%b key_idx=%0d data=%h, required 1 0 0 0",
               ready, valid, key_idx, data_out);
    end
    for (int n = 0; n < 30; n++) begin
      step();
      n_checks++;
      if (valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_no_valid: valid=%b required 0", valid);
      end
    end
    c = rnd128(); exp_c = encrypt(c);
    start_op(c);
    for (int n = 1; n <= 35; n++) begin
      n_checks++;
      if (valid !== (n == 35)) begin
        n_fail++;
        $display("FAIL mid_reset_restart_valid: cycle T+%0d valid=%b required %b", n, valid, (n == 35));
      end
      if (n == 35) begin
        n_checks++;
        if (fp(data_out) !== exp_c) begin
          n_fail++;
          $display("FAIL mid_reset_restart_result: got %h required %h", fp(data_out), exp_c);
        end
      end
      step();
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = 128'd0;
    for (int n = 0; n < 33; n++) ram[n] = 128'd0;
    test_reset();
    test_known_answer();
    test_key_addressing();
    test_busy_start();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
